// File: rtl/hwjsoc_fetch_pkg.sv
// rtl/hwjsoc_fetch_pkg.sv - shared constants and types for the instruction fetch unit
package hwjsoc_fetch_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam int          ADDR_W_DEFAULT   = 13;
   localparam int          FIFO_DEPTH       = 2;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_FETCH = 1'b1
   } fetch_state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] data;
   } fetch_entry_t;

endpackage

// File: rtl/hwjsoc_fetch_fifo.sv
// rtl/hwjsoc_fetch_fifo.sv - two-entry instruction buffer holding {pc, data} pairs
module hwjsoc_fetch_fifo
   import hwjsoc_fetch_pkg::*;
(
   input  logic         clk_i,
   input  logic         reset_i,
   input  logic         clear_i,
   input  logic         push_i,
   input  fetch_entry_t push_entry_i,
   input  logic         pop_i,
   output fetch_entry_t head_o,
   output logic [1:0]   count_o
);

   fetch_entry_t mem_q [FIFO_DEPTH];
   logic         rd_ptr_q;
   logic         wr_ptr_q;
   logic [1:0]   count_q;

   // Clear only rewinds the pointers; stale payload is harmless once count is zero.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else if (clear_i) begin
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (push_i) begin
            mem_q[wr_ptr_q] <= push_entry_i;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop_i) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         count_q <= count_q + {1'b0, push_i} - {1'b0, pop_i};
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

   a_no_overflow: assert property (@(posedge clk_i) disable iff (reset_i || clear_i)
      !(push_i && !pop_i && count_q == 2'(FIFO_DEPTH)));

   a_no_underflow: assert property (@(posedge clk_i) disable iff (reset_i || clear_i)
      !(pop_i && count_q == 2'd0));

endmodule

// File: rtl/hwjsoc_inst_fetch.sv
// rtl/hwjsoc_inst_fetch.sv - instruction fetch: issue/redirect control in front of a 2-entry buffer
module hwjsoc_inst_fetch
   import hwjsoc_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int          ADDR_W   = ADDR_W_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              fetch_en,
   input  logic              redirect_valid,
   input  logic [31:0]       redirect_pc,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_chipselect,
   output logic              mem_write,
   output logic [3:0]        mem_byteenable,
   output logic              mem_clken,
   input  logic [31:0]       mem_readdata,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [31:0]       instr_data,
   output logic [31:0]       instr_pc
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic         inflight_q;
   logic [31:0]  inflight_pc_q;

   logic [31:0]  redirect_base;
   logic [31:0]  issue_pc;
   logic [1:0]   fifo_count;
   logic [2:0]   occupancy;
   logic         pop;
   logic         issue;
   logic         capture;
   fetch_entry_t head;
   fetch_entry_t capture_entry;

   assign redirect_base = redirect_pc & ~32'h3;
   assign issue_pc      = redirect_valid ? redirect_base : pc_q;
   assign pop           = instr_valid & instr_ready;

   // Occupancy after this cycle's capture and pop; a redirect flushes everything, so it may always issue.
   assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
   assign issue     = !reset && (state_q == ST_FETCH) && fetch_en
                      && (redirect_valid || (occupancy < 3'(FIFO_DEPTH)));
   assign capture   = inflight_q & ~redirect_valid;

   assign capture_entry = '{pc: inflight_pc_q, data: mem_readdata};

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  state_d = ST_FETCH;
         ST_FETCH: state_d = ST_FETCH;
         default:  state_d = ST_IDLE;
      endcase
      pc_d = issue ? (issue_pc + 32'd4) : issue_pc;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         pc_q          <= RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= 32'd0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         inflight_q <= issue;
         if (issue) begin
            inflight_pc_q <= issue_pc;
         end
      end
   end

   hwjsoc_fetch_fifo u_fifo (
      .clk_i        (clk),
      .reset_i      (reset),
      .clear_i      (redirect_valid),
      .push_i       (capture),
      .push_entry_i (capture_entry),
      .pop_i        (pop & ~redirect_valid),
      .head_o       (head),
      .count_o      (fifo_count)
   );

   assign mem_address    = issue_pc[ADDR_W+1:2];
   assign mem_chipselect = issue;
   assign mem_write      = 1'b0;
   assign mem_byteenable = 4'hF;
   assign mem_clken      = 1'b1;

   assign instr_valid = (fifo_count != 2'd0);
   assign instr_data  = head.data;
   assign instr_pc    = head.pc;

endmodule
